ysyx_22041412_ifetch_rsp: RTL and testbench

- Responder end of the instruction-fetch read handshake.
- Accepts one fetch request (valid, address, byte-mask size) from the fetch stage and issues a single AXI4-Lite read on the memory side.
- Returns the selected instruction word on the low bits of the response data, together with a one-cycle ready pulse.
- Sits between the fetch unit and the AXI crossbar/memory port.

---
 rtl/ysyx_22041412_ifetch_rsp.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22041412_ifetch_rsp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_ifetch_rsp.sv
// ysyx_22041412_ifetch_rsp: responder end of the instruction-fetch handshake.
// Turns one fetch request into a single AXI4-Lite read and returns the selected
// instruction word on the low bits of rsp_data_o with a one-cycle ready pulse.
// Optional feature macro: YSYX_22041412_IFETCH_LINEBUF_EN adds a one-entry
// 64-bit line buffer that answers repeat fetches from the same beat locally.
module ysyx_22041412_ifetch_rsp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_ack_i,
    input  logic [7:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_ready_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [2:0]        ar_prot_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    output logic [31:0]       fetch_cnt_o
);

    localparam int HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

    state_e            state_q, state_d;
    logic              word_hi_q, word_hi_d;
    logic              size_dw_q, size_dw_d;
    logic              ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic              r_ready_q, r_ready_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic              req_size_legal;
    logic              unused_addr_bits;

`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-4:0] buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              buf_hit;

    assign buf_hit = buf_valid_q && (buf_tag_q == req_addr_i[ADDR_W-1:3]);
`endif

    // The two lowest address bits never affect an 8-byte-aligned fetch.
    assign unused_addr_bits = ^req_addr_i[1:0];
    assign req_size_legal   = (req_size_i == 8'h0F) || (req_size_i == 8'hFF);

    // Selects the returned data: whole beat for 8-byte fetches, else the addressed half.
    function automatic logic [DATA_W-1:0] pick_word(input logic [DATA_W-1:0] beat,
                                                    input logic hi, input logic dw);
        logic [DATA_W-1:0] res;
        if (dw) begin
            res = beat;
        end else if (hi) begin
            res = {{HALF_W{1'b0}}, beat[DATA_W-1:HALF_W]};
        end else begin
            res = {{HALF_W{1'b0}}, beat[HALF_W-1:0]};
        end
        return res;
    endfunction

    // Next-state logic for the fetch FSM, its registered outputs and the fetch counter.
    always_comb begin
        state_d     = state_q;
        word_hi_d   = word_hi_q;
        size_dw_d   = size_dw_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        r_ready_d   = r_ready_q;
        rsp_ready_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fetch_cnt_d = fetch_cnt_q + {31'b0, req_ack_i};
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    word_hi_d = req_addr_i[2];
                    size_dw_d = (req_size_i == 8'hFF);
                    if (!req_size_legal) begin
                        state_d     = RESP;
                        rsp_ready_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
                    else if (buf_hit) begin
                        state_d     = RESP;
                        rsp_ready_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = pick_word(buf_data_q, req_addr_i[2], req_size_i == 8'hFF);
                    end
`endif
                    else begin
                        state_d    = AR;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = {req_addr_i[ADDR_W-1:3], 3'b000};
                    end
                end
            end
            AR: begin
                if (ar_ready_i) begin
                    state_d    = R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            R: begin
                if (r_valid_i) begin
                    state_d     = RESP;
                    r_ready_d   = 1'b0;
                    rsp_ready_d = 1'b1;
                    rsp_data_d  = pick_word(r_data_i, word_hi_q, size_dw_q);
                    rsp_err_d   = |r_resp_i;
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
                    if (r_resp_i == 2'b00) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = ar_addr_q[ADDR_W-1:3];
                        buf_data_d  = r_data_i;
                    end else begin
                        buf_valid_d = 1'b0;
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything back to an idle, silent port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_hi_q   <= 1'b0;
            size_dw_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            r_ready_q   <= 1'b0;
            rsp_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            fetch_cnt_q <= '0;
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_hi_q   <= word_hi_d;
            size_dw_q   <= size_dw_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            r_ready_q   <= r_ready_d;
            rsp_ready_q <= rsp_ready_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            fetch_cnt_q <= fetch_cnt_d;
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign ar_valid_o  = ar_valid_q;
    assign ar_addr_o   = ar_addr_q;
    assign ar_prot_o   = 3'b100;
    assign r_ready_o   = r_ready_q;
    assign rsp_ready_o = rsp_ready_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22041412_ifetch_rsp.sv
// Testbench for ysyx_22041412_ifetch_rsp: directed vector table, hand-written
// reset/counter/line-buffer sequences and a randomized run against a
// transaction-level reference model. Honours YSYX_22041412_IFETCH_LINEBUF_EN.
module tb_ysyx_22041412_ifetch_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ack_i;
    logic [7:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic        rsp_ready_o;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [31:0] ar_addr_o;
    logic [2:0]  ar_prot_o;
    logic        r_valid_i;
    logic        r_ready_o;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic [31:0] fetch_cnt_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;

    // Reference line buffer: last error-free beat and its 8-byte tag.
    bit          lb_valid;
    logic [28:0] lb_tag;
    logic [63:0] lb_word;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  size;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  ar_wait;
        logic [3:0]  r_wait;
        logic [63:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_lat;
        logic        exp_axi;
    } vec_t;

    vec_t  vecs [7];
    string vec_names [7];

    ysyx_22041412_ifetch_rsp #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ack_i(req_ack_i),
        .req_size_i(req_size_i), .req_addr_i(req_addr_i),
        .rsp_ready_o(rsp_ready_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic driveAck();
        req_ack_i = ($urandom_range(0, 3) == 0);
        if (req_ack_i) exp_cnt = exp_cnt + 32'd1;
    endtask

    function automatic logic [63:0] extractWord(input logic [31:0] addr, input logic [7:0] size,
                                                input logic [63:0] word);
        if (size == 8'hFF) return word;
        return (word >> (addr[2] * 32)) & 64'h0000_0000_FFFF_FFFF;
    endfunction

    // One complete fetch: starts at a negedge, ends at the negedge after the ready pulse.
    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [7:0] size,
                                 input logic [63:0] rdata, input logic [1:0] rresp,
                                 input int ar_wait, input int r_wait,
                                 input logic [63:0] exp_data, input logic exp_err,
                                 input int exp_lat, input logic exp_axi);
        int cyc = 0, ar_w = 0, r_w = 0, ar_hs = 0, r_hs = 0, got_lat = 0;
        bit done = 0, ar_bad = 0;
        logic [63:0] got_data = '0;
        logic got_err = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_size_i  = size;
        ar_ready_i  = 1'b0;
        r_valid_i   = 1'b0;
        driveAck();
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (ar_valid_o) begin
                if (ar_addr_o !== {addr[31:3], 3'b000}) ar_bad = 1;
                if (ar_w < ar_wait) begin ar_ready_i = 1'b0; ar_w++; end
                else begin ar_ready_i = 1'b1; ar_hs++; end
            end else begin
                ar_ready_i = 1'b0;
            end
            r_data_i = {$urandom, $urandom};
            r_resp_i = 2'($urandom_range(0, 3));
            if (r_ready_o) begin
                if (r_w < r_wait) begin r_valid_i = 1'b0; r_w++; end
                else begin r_valid_i = 1'b1; r_data_i = rdata; r_resp_i = rresp; r_hs++; end
            end else begin
                r_valid_i = 1'b0;
            end
            if (rsp_ready_o) begin
                done = 1; got_lat = cyc; got_data = rsp_data_o; got_err = rsp_err_o;
                req_valid_i = 1'b0;
            end else begin
                req_addr_i = $urandom;
                req_size_i = 8'($urandom);
            end
            driveAck();
        end
        checkOutput({name, "_done"}, 64'(done), 64'd1);
        checkOutput({name, "_data"}, got_data, exp_data);
        checkOutput({name, "_err"}, 64'(got_err), 64'(exp_err));
        checkOutput({name, "_latency"}, 64'(got_lat), 64'(exp_lat));
        checkOutput({name, "_ar_handshakes"}, 64'(ar_hs), 64'(exp_axi));
        checkOutput({name, "_r_handshakes"}, 64'(r_hs), 64'(exp_axi));
        checkOutput({name, "_ar_addr_stable"}, 64'(ar_bad), 64'd0);
        @(negedge clk);
        checkOutput({name, "_pulse_width"}, 64'(rsp_ready_o), 64'd0);
        checkOutput({name, "_data_hold"}, rsp_data_o, exp_data);
        checkOutput({name, "_err_hold"}, 64'(rsp_err_o), 64'(exp_err));
        checkOutput({name, "_axi_quiet"}, {62'd0, ar_valid_o, r_ready_o}, 64'd0);
        checkOutput({name, "_fetch_cnt"}, 64'(fetch_cnt_o), 64'(exp_cnt));
        req_ack_i  = 1'b0;
        ar_ready_i = 1'b0;
        r_valid_i  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        req_valid_i = 1'b0; req_ack_i = 1'b0; ar_ready_i = 1'b0; r_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt  = '0;
        lb_valid = 0;
    endtask

    initial begin
        vecs[0] = '{32'h8000_0004, 8'h0F, 64'h1111_2222_3333_4444, 2'b00, 4'd0, 4'd0,
                    64'h0000_0000_1111_2222, 1'b0, 8'd3, 1'b1};
        vec_names[0] = "word_hi_zero_wait";
        vecs[1] = '{32'h8000_0010, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 4'd0, 4'd0,
                    64'hDEAD_BEEF_CAFE_F00D, 1'b1, 8'd3, 1'b1};
        vec_names[1] = "slverr_dword";
        vecs[2] = '{32'h8000_0000, 8'h0F, 64'h1111_2222_3333_4444, 2'b00, 4'd4, 4'd3,
                    64'h0000_0000_3333_4444, 1'b0, 8'd10, 1'b1};
        vec_names[2] = "backpressure";
        vecs[3] = '{32'h8000_0028, 8'hFF, 64'h0123_4567_89AB_CDEF, 2'b00, 4'd1, 4'd0,
                    64'h0123_4567_89AB_CDEF, 1'b0, 8'd4, 1'b1};
        vec_names[3] = "dword";
        vecs[4] = '{32'h8000_0100, 8'h03, 64'h0, 2'b00, 4'd0, 4'd0,
                    64'h0, 1'b1, 8'd1, 1'b0};
        vec_names[4] = "illegal_size";
        vecs[5] = '{32'h8000_010C, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 2'b01, 4'd0, 4'd2,
                    64'h0000_0000_AAAA_BBBB, 1'b1, 8'd5, 1'b1};
        vec_names[5] = "exokay_err_word";
        vecs[6] = '{32'h8000_0200, 8'h0F, 64'h5555_6666_7777_8888, 2'b00, 4'd2, 4'd1,
                    64'h0000_0000_7777_8888, 1'b0, 8'd6, 1'b1};
        vec_names[6] = "word_lo";

        rst = 1'b0;
        req_valid_i = 1'b0; req_ack_i = 1'b0; req_size_i = '0; req_addr_i = '0;
        ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0;
        exp_cnt = '0; lb_valid = 0; lb_tag = '0; lb_word = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {58'd0, rsp_ready_o, rsp_err_o, ar_valid_o, r_ready_o, 2'b00}, 64'd0);
        checkOutput("reset_rsp_data", rsp_data_o, 64'd0);
        checkOutput("reset_ar_addr", 64'(ar_addr_o), 64'd0);
        checkOutput("reset_fetch_cnt", 64'(fetch_cnt_o), 64'd0);
        checkOutput("ar_prot_const", 64'(ar_prot_o), 64'd4);
        rst = 1'b1;

        // Counter: three pulses, then wrap from all-ones.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req_ack_i = 1'b1;
            @(negedge clk); req_ack_i = 1'b0;
        end
        @(negedge clk);
        checkOutput("cnt_three", 64'(fetch_cnt_o), 64'd3);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        #1;
        checkOutput("cnt_preload", 64'(fetch_cnt_o), 64'h0000_0000_FFFF_FFFF);
        req_ack_i = 1'b1;
        @(negedge clk);
        req_ack_i = 1'b0;
        checkOutput("cnt_wrap", 64'(fetch_cnt_o), 64'd0);
        exp_cnt = '0;

        // Directed vector table, applied back to back.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vec_names[i], vecs[i].addr, vecs[i].size, vecs[i].rdata, vecs[i].rresp,
                          int'(vecs[i].ar_wait), int'(vecs[i].r_wait), vecs[i].exp_data,
                          vecs[i].exp_err, int'(vecs[i].exp_lat), vecs[i].exp_axi);
        end

        // Asynchronous reset while waiting in R.
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0040; req_size_i = 8'hFF;
        req_ack_i = 1'b1; ar_ready_i = 1'b1;
        @(negedge clk);
        req_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("mid_r_reached", 64'(r_ready_o), 64'd1);
        ar_ready_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_r_reset_ctrl", {60'd0, ar_valid_o, r_ready_o, rsp_ready_o, rsp_err_o}, 64'd0);
        checkOutput("mid_r_reset_cnt", 64'(fetch_cnt_o), 64'd0);
        checkOutput("mid_r_reset_data", rsp_data_o, 64'd0);
        checkOutput("mid_r_reset_ar_addr", 64'(ar_addr_o), 64'd0);
        @(negedge clk);
        rst = 1'b1; req_valid_i = 1'b0;
        exp_cnt = '0; lb_valid = 0;
        applyStimulus("after_reset", 32'h8000_0040, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 0, 1,
                      64'h0F0E_0D0C_0B0A_0908, 1'b0, 4, 1'b1);

`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
        // Line buffer: fill, hit on the upper word, then miss on the next beat.
        applyStimulus("lb_fill", 32'h8000_0000, 8'h0F, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00, 0, 0,
                      64'h0000_0000_5A5A_5A5A, 1'b0, 3, 1'b1);
        applyStimulus("lb_hit", 32'h8000_0004, 8'h0F, 64'h0, 2'b00, 0, 0,
                      64'h0000_0000_A5A5_A5A5, 1'b0, 1, 1'b0);
        applyStimulus("lb_miss", 32'h8000_0008, 8'hFF, 64'h1234_5678_9ABC_DEF0, 2'b00, 0, 0,
                      64'h1234_5678_9ABC_DEF0, 1'b0, 3, 1'b1);
`endif

        // Randomized transactions against the reference model.
        doReset();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            logic [7:0]  size;
            logic [63:0] rdata, edata;
            logic [1:0]  rresp;
            int          arw, rw, pick, elat;
            logic        eerr, eaxi;
            addr  = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
            pick  = $urandom_range(0, 19);
            size  = (pick < 9) ? 8'h0F : (pick < 18) ? 8'hFF : 8'h01 + 8'($urandom_range(0, 13));
            rdata = {$urandom, $urandom};
            rresp = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            arw   = $urandom_range(0, 3);
            rw    = $urandom_range(0, 3);
            if (size != 8'h0F && size != 8'hFF) begin
                edata = '0; eerr = 1'b1; eaxi = 1'b0; elat = 1;
            end
`ifdef YSYX_22041412_IFETCH_LINEBUF_EN
            else if (lb_valid && addr[31:3] == lb_tag) begin
                edata = extractWord(addr, size, lb_word); eerr = 1'b0; eaxi = 1'b0; elat = 1;
            end
`endif
            else begin
                edata = extractWord(addr, size, rdata);
                eerr  = (rresp != 2'b00);
                eaxi  = 1'b1;
                elat  = 3 + arw + rw;
                if (rresp == 2'b00) begin
                    lb_valid = 1; lb_tag = addr[31:3]; lb_word = rdata;
                end else begin
                    lb_valid = 0;
                end
            end
            applyStimulus($sformatf("rand%0d", n), addr, size, rdata, rresp, arw, rw,
                          edata, eerr, elat, eaxi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
